// File: rtl/pipeline_control_pkg.sv
// Shared types and constants for the pipeline-control sequencer and its helpers.
package pipeline_control_pkg;

    localparam int PL_REQ_NUM = 4;

    typedef logic [1:0] pl_req_id_t;

    localparam pl_req_id_t PL_REQ_EXCEPT     = 2'd0;
    localparam pl_req_id_t PL_REQ_IRQ_CALL   = 2'd1;
    localparam pl_req_id_t PL_REQ_IRQ_RETURN = 2'd2;
    localparam pl_req_id_t PL_REQ_SYSREG     = 2'd3;

    typedef enum logic [2:0] {
        PL_IDLE  = 3'd0,
        PL_FLUSH = 3'd1,
        PL_START = 3'd2,
        PL_WAIT  = 3'd3,
        PL_DONE  = 3'd4
    } pl_state_t;

    function automatic logic [PL_REQ_NUM-1:0] pl_onehot(input pl_req_id_t id);
        logic [PL_REQ_NUM-1:0] vec;
        vec     = '0;
        vec[id] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/pipeline_control_req_pending.sv
// Pending-request latch with fixed-priority selection (lowest bit index wins).
module pipeline_control_req_pending
    import pipeline_control_pkg::*;
(
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iRESET_SYNC,
    input  logic [PL_REQ_NUM-1:0] req,
    input  logic                  clear,
    output logic                  valid,
    output pl_req_id_t            id,
    output logic [PL_REQ_NUM-1:0] pending
);

    logic [PL_REQ_NUM-1:0] clear_mask;

    assign clear_mask = clear ? pl_onehot(id) : '0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            pending <= '0;
        end else if (iRESET_SYNC) begin
            pending <= '0;
        end else begin
            // A request landing on the bit being cleared survives the clear.
            pending <= (pending & ~clear_mask) | req;
        end
    end

    // NOTE: outputs get a default before the if-chain so no latch is inferred.
    always_comb begin
        valid = |pending;
        id    = PL_REQ_EXCEPT;
        if (pending[PL_REQ_EXCEPT])          id = PL_REQ_EXCEPT;
        else if (pending[PL_REQ_IRQ_CALL])   id = PL_REQ_IRQ_CALL;
        else if (pending[PL_REQ_IRQ_RETURN]) id = PL_REQ_IRQ_RETURN;
        else if (pending[PL_REQ_SYSREG])     id = PL_REQ_SYSREG;
    end

endmodule

// File: rtl/pipeline_control_sequencer.sv
// Arbitrates pipeline-control requests, drains the pipeline, then runs one
// sub-controller at a time under a watchdog.
module pipeline_control_sequencer
    import pipeline_control_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  iCLOCK,
    input  logic                  inRESET,
    input  logic                  iRESET_SYNC,
    input  logic [PL_REQ_NUM-1:0] iREQ,
    input  logic                  iPIPELINE_EMPTY,
    input  logic [PL_REQ_NUM-1:0] iFINISH,
    output logic                  oPIPELINE_STALL,
    output logic [PL_REQ_NUM-1:0] oSTART,
    output logic                  oBUSY,
    output logic [PL_REQ_NUM-1:0] oPENDING,
    output logic                  oDONE,
    output logic [1:0]            oDONE_ID,
    output logic                  oTIMEOUT
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    pl_state_t             state, state_next;
    pl_req_id_t            grant_id, grant_next;
    logic                  timeout_flag, flag_next;
    logic [CW-1:0]         count, count_next;
    logic                  grant_take;
    logic                  req_valid;
    pl_req_id_t            req_id;
    logic [PL_REQ_NUM-1:0] pending;

    pipeline_control_req_pending u_pending (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .req         (iREQ),
        .clear       (grant_take),
        .valid       (req_valid),
        .id          (req_id),
        .pending     (pending)
    );

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state        <= PL_IDLE;
            grant_id     <= PL_REQ_EXCEPT;
            timeout_flag <= 1'b0;
            count        <= '0;
        end else if (iRESET_SYNC) begin
            state        <= PL_IDLE;
            grant_id     <= PL_REQ_EXCEPT;
            timeout_flag <= 1'b0;
            count        <= '0;
        end else begin
            state        <= state_next;
            grant_id     <= grant_next;
            timeout_flag <= flag_next;
            count        <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        grant_next = grant_id;
        flag_next  = timeout_flag;
        count_next = count;
        grant_take = 1'b0;
        case (state)
            PL_IDLE: begin
                if (req_valid) begin
                    grant_take = 1'b1;
                    grant_next = req_id;
                    state_next = PL_FLUSH;
                end
            end
            PL_FLUSH: begin
                if (iPIPELINE_EMPTY) state_next = PL_START;
            end
            PL_START: begin
                count_next = '0;
                state_next = PL_WAIT;
            end
            PL_WAIT: begin
                // Finish takes precedence over a watchdog expiring in the same cycle.
                if (iFINISH[grant_id]) begin
                    flag_next  = 1'b0;
                    state_next = PL_DONE;
                end else if (count == COUNT_LAST) begin
                    flag_next  = 1'b1;
                    state_next = PL_DONE;
                end else begin
                    count_next = count + CW'(1);
                end
            end
            PL_DONE: begin
                state_next = PL_IDLE;
            end
            default: begin
                state_next = PL_IDLE;
            end
        endcase
    end

    assign oPIPELINE_STALL = (state != PL_IDLE);
    assign oBUSY           = (state != PL_IDLE);
    assign oPENDING        = pending;
    assign oSTART          = (state == PL_START) ? pl_onehot(grant_id) : '0;
    assign oDONE           = (state == PL_DONE);
    assign oDONE_ID        = (state == PL_DONE) ? grant_id : PL_REQ_EXCEPT;
    assign oTIMEOUT        = (state == PL_DONE) && timeout_flag;

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Directed bench for the pipeline-control sequencer, watchdog shortened to 4 cycles.
module tb_pipeline_control_sequencer;
    import pipeline_control_pkg::*;

    logic       iCLOCK;
    logic       inRESET;
    logic       iRESET_SYNC;
    logic [3:0] iREQ;
    logic       iPIPELINE_EMPTY;
    logic [3:0] iFINISH;
    logic       oPIPELINE_STALL;
    logic [3:0] oSTART;
    logic       oBUSY;
    logic [3:0] oPENDING;
    logic       oDONE;
    logic [1:0] oDONE_ID;
    logic       oTIMEOUT;

    int total = 0;
    int bad   = 0;

    pipeline_control_sequencer #(.TIMEOUT_CYCLES(4)) dut (
        .iCLOCK          (iCLOCK),
        .inRESET         (inRESET),
        .iRESET_SYNC     (iRESET_SYNC),
        .iREQ            (iREQ),
        .iPIPELINE_EMPTY (iPIPELINE_EMPTY),
        .iFINISH         (iFINISH),
        .oPIPELINE_STALL (oPIPELINE_STALL),
        .oSTART          (oSTART),
        .oBUSY           (oBUSY),
        .oPENDING        (oPENDING),
        .oDONE           (oDONE),
        .oDONE_ID        (oDONE_ID),
        .oTIMEOUT        (oTIMEOUT)
    );

    initial iCLOCK = 1'b0;
    always #5 iCLOCK = ~iCLOCK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outs"}, {oPIPELINE_STALL, oSTART, oBUSY, oPENDING, oDONE, oDONE_ID, oTIMEOUT}, 0);
    endtask

    // Pulse req at cycle 0, optional late_req at cycle 2; returns in the first WAIT cycle (4).
    task automatic to_wait(input logic [3:0] req, input logic [3:0] late_req);
        iREQ = req;
        tick();
        iREQ = '0;
        tick();
        iREQ = late_req;
        tick();
        iREQ = '0;
        tick();
    endtask

    // From any point before START: wait for the start, finish one cycle later, check DONE.
    task automatic serve(input string tag, input pl_req_id_t id_exp);
        int n;
        logic [3:0] oh;
        oh = pl_onehot(id_exp);
        n  = 0;
        while (oSTART == 4'd0 && n < 40) begin
            tick();
            n++;
        end
        check({tag, ".start"}, oSTART, oh);
        tick();
        iFINISH = oh;
        tick();
        iFINISH = '0;
        check({tag, ".done"}, oDONE, 1);
        check({tag, ".done_id"}, oDONE_ID, id_exp);
        check({tag, ".timeout"}, oTIMEOUT, 0);
        tick();
    endtask

    initial begin
        int dones;
        int activity;

        inRESET         = 1'b0;
        iRESET_SYNC     = 1'b0;
        iREQ            = '0;
        iPIPELINE_EMPTY = 1'b1;
        iFINISH         = '0;
        tick();
        tick();
        check_all_zero("reset");
        inRESET = 1'b1;
        tick();
        check_all_zero("post_reset");

        // Single IRQ return with 1-cycle sub-controller.
        iREQ = 4'b0100;
        tick();
        iREQ = '0;
        check("single.c1_pending", oPENDING, 4'b0100);
        check("single.c1_busy", oBUSY, 0);
        tick();
        check("single.c2_stall", oPIPELINE_STALL, 1);
        check("single.c2_pending", oPENDING, 4'b0000);
        check("single.c2_start", oSTART, 4'b0000);
        tick();
        check("single.c3_start", oSTART, 4'b0100);
        tick();
        check("single.c4_start", oSTART, 4'b0000);
        iFINISH = 4'b0100;
        tick();
        iFINISH = '0;
        check("single.c5_done", oDONE, 1);
        check("single.c5_id", oDONE_ID, 2);
        check("single.c5_timeout", oTIMEOUT, 0);
        tick();
        check("single.c6_stall", oPIPELINE_STALL, 0);
        check("single.c6_done", oDONE, 0);

        // Priority, with exception injected during WAIT of ID 1.
        iREQ = 4'b1110;
        tick();
        iREQ = '0;
        check("prio.pending", oPENDING, 4'b1110);
        tick();
        check("prio.after_grant", oPENDING, 4'b1100);
        tick();
        check("prio.start1", oSTART, 4'b0010);
        tick();
        iREQ    = 4'b0001;
        iFINISH = 4'b0010;
        tick();
        iREQ    = '0;
        iFINISH = '0;
        check("prio.done1", oDONE, 1);
        check("prio.done1_id", oDONE_ID, 1);
        check("prio.pending_exc", oPENDING, 4'b1101);
        tick();
        serve("prio.exc", PL_REQ_EXCEPT);
        serve("prio.ret", PL_REQ_IRQ_RETURN);
        serve("prio.sys", PL_REQ_SYSREG);
        check("prio.drained", oPENDING, 4'b0000);
        check("prio.idle", oBUSY, 0);

        // Drain wait: FLUSH held for 10 cycles.
        iPIPELINE_EMPTY = 1'b0;
        iREQ = 4'b0001;
        tick();
        iREQ = '0;
        tick();
        for (int i = 0; i < 10; i++) begin
            check("drain.stall", oPIPELINE_STALL, 1);
            check("drain.no_start", oSTART, 4'b0000);
            tick();
        end
        check("drain.still_flush", oSTART, 4'b0000);
        iPIPELINE_EMPTY = 1'b1;
        tick();
        check("drain.start", oSTART, 4'b0001);
        tick();
        iFINISH = 4'b0001;
        tick();
        iFINISH = '0;
        check("drain.done", oDONE, 1);
        check("drain.done_id", oDONE_ID, 0);
        tick();

        // Watchdog expiry with a wrong-ID finish present.
        to_wait(4'b0100, 4'b0000);
        iFINISH = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wdog.no_done", oDONE, 0);
        end
        tick();
        iFINISH = '0;
        check("wdog.done", oDONE, 1);
        check("wdog.timeout", oTIMEOUT, 1);
        check("wdog.id", oDONE_ID, 2);
        tick();
        check("wdog.idle", oBUSY, 0);

        // Finish on the last watchdog cycle counts as success.
        to_wait(4'b0100, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wlast.no_done", oDONE, 0);
        end
        iFINISH = 4'b0100;
        tick();
        iFINISH = '0;
        check("wlast.done", oDONE, 1);
        check("wlast.timeout", oTIMEOUT, 0);
        tick();

        // Synchronous reset in WAIT with sysreg pending.
        to_wait(4'b0100, 4'b1000);
        check("sreset.pending", oPENDING, 4'b1000);
        check("sreset.busy", oBUSY, 1);
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        check_all_zero("sreset");
        activity = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            activity += int'(oBUSY) + int'(|oSTART);
        end
        check("sreset.no_grant", activity, 0);

        // Asynchronous reset asserted between edges.
        to_wait(4'b0100, 4'b1000);
        check("areset.pending", oPENDING, 4'b1000);
        #2;
        inRESET = 1'b0;
        #1;
        check_all_zero("areset");
        #1;
        inRESET = 1'b1;
        activity = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            activity += int'(oBUSY) + int'(|oSTART);
        end
        check("areset.no_grant", activity, 0);

        // Re-request of bit 2 in its own grant cycle: serviced twice.
        iREQ = 4'b0100;
        tick();
        check("merge.pending", oPENDING, 4'b0100);
        tick();
        iREQ = '0;
        check("merge.kept", oPENDING, 4'b0100);
        check("merge.busy", oBUSY, 1);
        serve("merge.first", PL_REQ_IRQ_RETURN);
        serve("merge.second", PL_REQ_IRQ_RETURN);
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            dones += int'(oDONE);
        end
        check("merge.no_third", dones, 0);
        check("merge.pending_end", oPENDING, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
